zkbd_matrix: RTL
================

// Module: zkbd_matrix
// PURPOSE
//  Consumes the byte-serialised ZX keyboard stream from the AVR SPI slave (kbd_out/kbd_out_sel/kbd_stb).
//  Assembles the 5 bytes into a 40-key shadow matrix and commits it atomically to the active matrix.
//  Serves Z80 port #FE reads: returns D4..D0 for the half-rows selected by A15..A8.
//  A watchdog releases all keys if the AVR stops sending complete frames.
// PARAMETERS
//  NBYTES   5           bytes per frame (8 half-rows x 5 keys = 40 bits)
//  TIMEOUT  14_000_000  fclk cycles without a commit before the active matrix is forced released
// PORTS
//  fclk         in   1  system clock; single clock domain
//  rst          in   1  synchronous, active-high reset
//  kbd_out      in   8  keyboard byte from SPI slave, 0 = pressed
//  kbd_out_sel  in   3  byte index within frame, 0..NBYTES-1
//  kbd_stb      in   1  one-cycle strobe, kbd_out/kbd_out_sel valid
//  kbd_a        in   8  Z80 A15..A8 of current #FE read; bit r = 0 selects half-row r
//  kbd_keys     out  5  D4..D0 for port #FE, 0 = pressed
//  kbd_upd      out  1  one-cycle pulse on each frame commit
//  kbd_stale    out  1  1 = no valid frame since reset or watchdog expiry
// BEHAVIOUR
//  Reset (rst=1 at posedge fclk):
//   - shadow and active matrices = all 1s; kbd_keys = 5'h1F; kbd_upd = 0; kbd_stale = 1
//   - expected index = 0; frame_ok = 0; watchdog = 0
//   - rst mid-frame discards the partial frame
//  Frame assembly, on each kbd_stb:
//   - sel >= NBYTES: ignored; no state change
//   - sel == 0: shadow[7:0] <= kbd_out; frame_ok <= 1; expected <= 1
//   - sel == expected and frame_ok: shadow[8*sel+7 : 8*sel] <= kbd_out; expected <= expected+1
//   - any other sel: frame_ok <= 0; bytes discarded until the next sel == 0
//   - sel == NBYTES-1 accepted with frame_ok:
//     - next cycle: active <= {kbd_out, shadow lower bytes}; kbd_upd = 1 for exactly one cycle
//     - kbd_stale <= 0; watchdog <= 0; expected <= 0; frame_ok <= 0
//   - Committing uses the just-strobed byte directly, so there is no extra frame latency.
//  Matrix mapping:
//   - half-row r (0..7) = active[5r+4 : 5r]
//   - bit 0 = key nearest the edge (CS, A, Q, 1, 0, P, Enter, Space)
//  Port read:
//   - kbd_keys <= AND over r of (kbd_a[r] ? 5'h1F : row r); registered, 1 fclk latency from kbd_a
//   - kbd_a = 8'hFF gives 5'h1F; kbd_a = 8'h00 gives the AND of all rows
//   - A read in the commit cycle returns the old matrix; the next cycle returns the new one (no tearing).
//  Watchdog:
//   - counts fclk cycles and saturates at TIMEOUT
//   - on reaching TIMEOUT: active <= all 1s; kbd_stale <= 1
//   - shadow and frame progress are preserved
//   - commit and expiry in the same cycle: commit wins, counter cleared
//  Widths:
//   - watchdog width = $clog2(TIMEOUT+1); no wrap
//   - expected is 3 bits; it never exceeds NBYTES
// TESTING
//  - Reset, then kbd_a = 8'h00 -> kbd_keys = 5'h1F, kbd_stale = 1, kbd_upd = 0.
//  - Frame bytes FE,FF,FF,FF,FF at sel 0..4, then kbd_a = 8'hFE
//    -> kbd_upd pulses once, kbd_keys = 5'h1E (CS), kbd_stale = 0.
//  - Sequence 0,1,3,4 -> no kbd_upd, active unchanged; a following full 0..4 frame commits normally.
//  - Strobe with sel = 6 mid-frame -> ignored; the frame still commits on sel 4.
//  - Two rows pressed, kbd_a = 8'h7E -> AND of rows 0 and 7; kbd_a = 8'hFF -> 5'h1F; check 1-cycle latency.
//  - TIMEOUT = 100, no frames after a commit -> at cycle 100 kbd_keys = 5'h1F and kbd_stale = 1;
//    a commit landing exactly at expiry leaves kbd_stale = 0.

Source files
------------

// File: rtl/zkbd_if.sv
// Keyboard stream / port #FE bundle between the AVR SPI slave side, the Z80 read path and zkbd_matrix.
interface zkbd_if;
    logic [7:0] kbd_out;
    logic [2:0] kbd_out_sel;
    logic       kbd_stb;
    logic [7:0] kbd_a;
    logic [4:0] kbd_keys;
    logic       kbd_upd;
    logic       kbd_stale;

    modport master (
        output kbd_out, kbd_out_sel, kbd_stb, kbd_a,
        input  kbd_keys, kbd_upd, kbd_stale
    );

    modport slave (
        input  kbd_out, kbd_out_sel, kbd_stb, kbd_a,
        output kbd_keys, kbd_upd, kbd_stale
    );
endinterface

// File: rtl/zkbd_matrix.sv
// ZX keyboard matrix: assembles byte frames from the AVR into a shadow matrix and commits them atomically.
// Also serves port #FE half-row reads and releases all keys when frames stop arriving.
module zkbd_matrix #(
    parameter int NBYTES  = 5,
    parameter int TIMEOUT = 14_000_000
) (
    input logic   fclk,
    input logic   rst,
    zkbd_if.slave kbd
);
    localparam int                MW       = 8 * NBYTES;
    localparam int                WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]   WD_MAX   = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0]   WD_PRE   = WD_W'(TIMEOUT - 1);
    localparam logic [2:0]        LAST_SEL = 3'(NBYTES - 1);

    logic [MW-1:0]   shadow;
    logic [MW-1:0]   active;
    logic [MW-1:0]   shadow_wr;
    logic [2:0]      expected;
    logic            frame_ok;
    logic [WD_W-1:0] wd;
    logic [4:0]      keys_q;
    logic [4:0]      keys_nxt;
    logic            upd_q;
    logic            stale_q;

    logic valid_sel;
    logic start;
    logic accept;
    logic commit;

    assign valid_sel = kbd.kbd_stb && (kbd.kbd_out_sel <= LAST_SEL);
    assign start     = valid_sel && (kbd.kbd_out_sel == 3'd0);
    assign accept    = valid_sel && frame_ok && (kbd.kbd_out_sel == expected) && !start;
    assign commit    = accept && (kbd.kbd_out_sel == LAST_SEL);

    // Shadow with the strobed byte merged in; committing this lets the last byte land without an extra cycle.
    always_comb begin
        // NOTE: assign a default before any conditional update so no latch is inferred.
        shadow_wr = shadow;
        for (int b = 0; b < NBYTES; b++) begin
            if (kbd.kbd_out_sel == 3'(b)) shadow_wr[8*b +: 8] = kbd.kbd_out;
        end
    end

    // A half-row joins the AND when its address line is low.
    always_comb begin
        keys_nxt = 5'h1F;
        for (int r = 0; r < 8; r++) begin
            if (!kbd.kbd_a[r]) keys_nxt = keys_nxt & active[5*r +: 5];
        end
    end

    always_ff @(posedge fclk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            shadow   <= '1;
            active   <= '1;
            keys_q   <= 5'h1F;
            upd_q    <= 1'b0;
            stale_q  <= 1'b1;
            expected <= 3'd0;
            frame_ok <= 1'b0;
            wd       <= '0;
        end else begin
            upd_q  <= commit;
            keys_q <= keys_nxt;

            if (start || accept) shadow <= shadow_wr;

            if (start) begin
                frame_ok <= 1'b1;
                expected <= 3'd1;
            end else if (commit) begin
                frame_ok <= 1'b0;
                expected <= 3'd0;
            end else if (accept) begin
                expected <= expected + 3'd1;
            end else if (valid_sel) begin
                frame_ok <= 1'b0;
            end

            // Commit outranks watchdog expiry landing on the same edge.
            if (commit) begin
                active  <= shadow_wr;
                stale_q <= 1'b0;
                wd      <= '0;
            end else if (wd >= WD_PRE) begin
                active  <= '1;
                stale_q <= 1'b1;
                wd      <= WD_MAX;
            end else begin
                wd <= wd + 1'b1;
            end
        end
    end

    assign kbd.kbd_keys  = keys_q;
    assign kbd.kbd_upd   = upd_q;
    assign kbd.kbd_stale = stale_q;
endmodule
